data_sampler: RTL
=================

Name: data_sampler

Overview:
- UART RX oversampling stage, directly upstream of the deserializer.
- Synchronises RX_IN through a 2-flop chain.
- Takes three samples per bit just before the bit midpoint and majority-votes them into sampled_bit.
- sampled_bit is stable in the cycle where edge_cnt == Prescale>>1, which is the cycle the deserializer captures it. The block also flags noisy bits for the parity and stop checkers.

Parameters:
- Prescale_width, 6: width of Prescale and edge_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- dat_samp_en  input  1  sampling enable from the RX FSM.
- RX_IN  input  1  raw serial line, asynchronous, idle high.
- Prescale  input  Prescale_width  oversampling ratio (clk cycles per bit).
- edge_cnt  input  Prescale_width  position within the current bit, 0..Prescale-1, from the edge/bit counter.
- sampled_bit  output  1  voted bit value, registered.
- sample_done  output  1  one-cycle pulse: sampled_bit updated this cycle.
- noise_flag  output  1  the last vote was not unanimous.

Behaviour:
- Clock and reset: single clock `clk`. Reset `reset_n` is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - sync chain = 2'b11
  - s0 = s1 = 1
  - sampled_bit = 1
  - sample_done = 0
  - noise_flag = 0
- Synchroniser: rx_s = RX_IN delayed 2 clk cycles. It runs regardless of dat_samp_en. All sampling below uses rx_s, never RX_IN.
- mid = Prescale >> 1, computed unsigned at Prescale_width bits.
- Triple mode (Prescale >= 8), at a clk edge with dat_samp_en = 1:
  - edge_cnt == mid-3: s0 <= rx_s.
  - edge_cnt == mid-2: s1 <= rx_s.
  - edge_cnt == mid-1: sampled_bit <= majority(s0, s1, rx_s). In the same edge, noise_flag <= !(s0 == s1 && s1 == rx_s) and sample_done <= 1.
- Single mode (2 <= Prescale <= 7):
  - At edge_cnt == mid-1: sampled_bit <= rx_s, noise_flag <= 0, sample_done <= 1.
  - s0 and s1 are unused.
- Prescale < 2: no update ever. sampled_bit holds and sample_done stays 0.
- Latency: sampled_bit and sample_done change at the edge ending cycle edge_cnt == mid-1. They are therefore valid throughout the cycle edge_cnt == mid.
- sample_done is high for exactly one cycle per bit, and only at the vote edge. All other edges it is 0.
- Between votes, sampled_bit and noise_flag hold their values.
- dat_samp_en = 0:
  - No capture and no vote.
  - s0 and s1 are set to 1 at the next edge.
  - noise_flag <= 0 and sample_done <= 0.
  - sampled_bit holds its value.
- Enable is checked per edge. If dat_samp_en drops between captures, the partially captured s0/s1 are discarded (forced to 1). A vote taken after re-enable uses whatever s0/s1 hold, so the RX FSM must enable the block before edge_cnt reaches mid-3 of the first bit.
- edge_cnt values that match no capture point cause no action. Skipped or jumping counts are tolerated and no error is raised.
- Prescale changing mid-bit is unsupported. Results for that bit are undefined, but the block must not lock up; the next full bit samples correctly.
- Reset asserted mid-bit forces all reset values immediately. After release, nothing happens until the next matching edge_cnt.
- Majority function: output 1 if at least two of the three inputs are 1.

Test Plan:
- Clean frame, Prescale = 8 (mid = 4, captures at edge_cnt 1/2/3), RX_IN = 0x55 LSB first, each bit held 8 cycles (sync delay accounted for) -> 8 sample_done pulses, each in the cycle edge_cnt == 4; sampled_bit sequence 1,0,1,0,1,0,1,0; noise_flag stays 0.
- Glitch rejection, Prescale = 16 (captures at edge_cnt 5/6/7): line at 1, rx_s forced 0 only at the edge_cnt == 6 capture -> sampled_bit = 1, noise_flag = 1, sample_done pulses once.
- Glitch on a 0 bit, Prescale = 32 (captures at 13/14/15): samples 0,1,0 -> sampled_bit = 0, noise_flag = 1; next clean bit clears noise_flag to 0.
- Single mode, Prescale = 4 (mid = 2): bit value 0 -> sampled_bit updates at the edge where edge_cnt == 1, noise_flag = 0; sample_done is high in the edge_cnt == 2 cycle only.
- Enable gating, Prescale = 8: dat_samp_en = 0 for a whole bit with RX_IN = 0 -> no sample_done, sampled_bit holds 1, noise_flag 0. Drop enable after the edge_cnt == 1 capture and re-enable before the next bit -> the next vote reflects only fresh samples.
- Async reset, Prescale = 8: assert reset_n = 0 at edge_cnt == 2 of a 0 bit -> outputs are immediately 1/0/0. Release; the next full bit of value 0 -> sampled_bit = 0 at edge_cnt == 4.

Source files
------------

// File: rtl/data_sampler.sv
// -----------------------------------------------------------------------------
// data_sampler
//
// UART receive oversampling stage. It sits directly in front of the
// deserializer. The raw serial line passes through a two-flop synchroniser.
// Three samples are then taken just before the bit midpoint and
// majority-voted into sampled_bit.
//
// The vote happens at the edge that ends the cycle edge_cnt == mid-1.
// As a result, sampled_bit is stable during the cycle edge_cnt == mid, which
// is the cycle in which the deserializer captures it. If the three samples
// disagree, noise_flag is raised so the parity and stop checkers can use it.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   dat_samp_en  sampling enable from the RX FSM
//   RX_IN        raw serial line (asynchronous, idle high)
//   Prescale     clk cycles per bit (oversampling ratio)
//   edge_cnt     position within the current bit, 0..Prescale-1
//   sampled_bit  voted bit value (registered)
//   sample_done  one-cycle pulse, high in the cycle after a vote
//   noise_flag   last vote was not unanimous
// -----------------------------------------------------------------------------
module data_sampler #(
   parameter int Prescale_width = 6
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      dat_samp_en,
   input  logic                      RX_IN,
   input  logic [Prescale_width-1:0] Prescale,
   input  logic [Prescale_width-1:0] edge_cnt,
   output logic                      sampled_bit,
   output logic                      sample_done,
   output logic                      noise_flag
);

   // Two-flop synchroniser. It resets to the idle-high line level, so that
   // no spurious start bit is seen when reset is released.
   logic [1:0] sync_reg;
   logic       rx_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], RX_IN};
      end
   end

   assign rx_s = sync_reg[1];

   // Capture points. All arithmetic is unsigned at the port width.
   // In triple mode mid >= 4, so the three points are distinct and none wraps.
   logic [Prescale_width-1:0] mid;
   logic [Prescale_width-1:0] cap0_pt;
   logic [Prescale_width-1:0] cap1_pt;
   logic [Prescale_width-1:0] vote_pt;
   logic                      triple_mode;
   logic                      single_mode;

   assign mid         = Prescale >> 1;
   assign cap0_pt     = mid - Prescale_width'(3);
   assign cap1_pt     = mid - Prescale_width'(2);
   assign vote_pt     = mid - Prescale_width'(1);
   assign triple_mode = (Prescale >= Prescale_width'(8));
   assign single_mode = (Prescale >= Prescale_width'(2)) && !triple_mode;

   // Sample and output registers
   logic s0_reg, s0_next;
   logic s1_reg, s1_next;
   logic sampled_bit_reg, sampled_bit_next;
   logic sample_done_reg, sample_done_next;
   logic noise_flag_reg, noise_flag_next;
   logic majority;

   assign majority = (s0_reg & s1_reg) | (s0_reg & rx_s) | (s1_reg & rx_s);

   always_comb begin
      s0_next          = s0_reg;
      s1_next          = s1_reg;
      sampled_bit_next = sampled_bit_reg;
      noise_flag_next  = noise_flag_reg;
      sample_done_next = 1'b0;

      if (!dat_samp_en) begin
         // Discard any partial capture so that a later vote cannot mix in
         // stale samples from an abandoned bit.
         s0_next         = 1'b1;
         s1_next         = 1'b1;
         noise_flag_next = 1'b0;
      end else if (triple_mode) begin
         if (edge_cnt == cap0_pt) begin
            s0_next = rx_s;
         end
         if (edge_cnt == cap1_pt) begin
            s1_next = rx_s;
         end
         if (edge_cnt == vote_pt) begin
            sampled_bit_next = majority;
            noise_flag_next  = !((s0_reg == s1_reg) && (s1_reg == rx_s));
            sample_done_next = 1'b1;
         end
      end else if (single_mode) begin
         // A bit is too short for three samples, so the line is taken as-is.
         if (edge_cnt == vote_pt) begin
            sampled_bit_next = rx_s;
            noise_flag_next  = 1'b0;
            sample_done_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_reg          <= 1'b1;
         s1_reg          <= 1'b1;
         sampled_bit_reg <= 1'b1;
         sample_done_reg <= 1'b0;
         noise_flag_reg  <= 1'b0;
      end else begin
         s0_reg          <= s0_next;
         s1_reg          <= s1_next;
         sampled_bit_reg <= sampled_bit_next;
         sample_done_reg <= sample_done_next;
         noise_flag_reg  <= noise_flag_next;
      end
   end

   assign sampled_bit = sampled_bit_reg;
   assign sample_done = sample_done_reg;
   assign noise_flag  = noise_flag_reg;

endmodule
